// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - sequential signed Q-format shift-add multiplier
// Optional feature: define MUL_SATURATE_EN to clamp out-of-range products instead of wrapping.

module mul_seq #(
    parameter int WIDTH = 16,
    parameter int QBITS = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_start,
    output logic [WIDTH-1:0] o_result,
    output logic             done,
    output logic             o_valid
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic               sign_q;

    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH-1:0]   trunc_mag;
    logic [WIDTH-1:0]   wrap_res;
    logic [WIDTH-1:0]   finish_res;
    logic [2*WIDTH-1:0] unused_acc;

    // |-2^(WIDTH-1)| still fits because the magnitude registers are unsigned
    assign a_abs = i_a[WIDTH-1] ? (~i_a + WIDTH'(1)) : i_a;
    assign b_abs = i_b[WIDTH-1] ? (~i_b + WIDTH'(1)) : i_b;

    // Dropping the fraction bits of the magnitude rounds the signed result toward zero
    assign trunc_mag = acc[QBITS+WIDTH-1:QBITS];
    assign wrap_res  = sign_q ? (~trunc_mag + WIDTH'(1)) : trunc_mag;
    assign unused_acc = acc;

`ifdef MUL_SATURATE_EN
    localparam int MW = 2*WIDTH - QBITS;
    localparam logic [MW-1:0] POS_LIM = {{(MW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [MW-1:0] NEG_LIM = {{(MW-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

    logic [MW-1:0] full_mag;

    assign full_mag = acc[2*WIDTH-1:QBITS];

    always_comb begin
        finish_res = wrap_res;
        if (!sign_q && (full_mag > POS_LIM)) begin
            finish_res = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (sign_q && (full_mag > NEG_LIM)) begin
            finish_res = {1'b1, {(WIDTH-1){1'b0}}};
        end
    end
`else
    assign finish_res = wrap_res;
`endif

    assign done = (state == S_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            sign_q   <= 1'b0;
            o_result <= '0;
            o_valid  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        mcand    <= {{WIDTH{1'b0}}, a_abs};
                        mplier   <= b_abs;
                        sign_q   <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
                        acc      <= '0;
                        cnt      <= '0;
                        o_valid  <= 1'b0;
                        o_result <= '0;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    // LSB-first: the multiplicand is pre-shifted to the current bit weight
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (cnt == CNT_LAST) begin
                        state <= S_FINISH;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_FINISH: begin
                    o_result <= finish_res;
                    o_valid  <= 1'b1;
                    cnt      <= '0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - randomized self-checking bench for mul_seq against a behavioural model

module tb_mul_seq;

    localparam int W = 16;
    localparam int Q = 8;
    localparam int LAT = W + 1;

    logic         clk;
    logic         rst;
    logic [W-1:0] ia;
    logic [W-1:0] ib;
    logic         start;
    logic [W-1:0] o_result;
    logic         done;
    logic         o_valid;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 0;

    logic         m_done;
    logic         m_valid;
    logic [W-1:0] m_result;
    logic [W-1:0] m_pending;
    int           m_left;

    mul_seq #(.WIDTH(W), .QBITS(Q)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_a      (ia),
        .i_b      (ib),
        .i_start  (start),
        .o_result (o_result),
        .done     (done),
        .o_valid  (o_valid)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Product from plain integer arithmetic: truncate magnitude, re-apply sign, then wrap or clamp
    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        longint m;
        longint r;
        logic [63:0] rv;
        p = longint'($signed(a)) * longint'($signed(b));
        m = ((p < 0) ? -p : p) >>> Q;
        r = (p < 0) ? -m : m;
`ifdef MUL_SATURATE_EN
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`endif
        rv = r;
        return rv[W-1:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Cycle-level handshake model: accept only when idle, result appears LAT edges later
    always @(posedge clk) begin
        if (rst) begin
            m_done = 1; m_valid = 0; m_result = '0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1; m_valid = 1; m_result = m_pending;
            end
        end else if (start && m_done) begin
            m_done = 0; m_valid = 0; m_result = '0;
            m_left = LAT;
            m_pending = ref_mul(ia, ib);
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("done", {31'd0, done}, {31'd0, m_done});
            check("o_valid", {31'd0, o_valid}, {31'd0, m_valid});
            check("o_result", {16'd0, o_result}, {16'd0, m_result});
        end
    end

    task automatic wait_valid(output int cyc);
        cyc = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (o_valid) return;
        end
        cyc = -1;
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] lit, input string name);
        int cyc;
        @(negedge clk);
        ia = a; ib = b; start = 1;
        @(negedge clk);
        start = 0;
        wait_valid(cyc);
        check({"latency_", name}, cyc, LAT);
        check(name, {16'd0, o_result}, {16'd0, lit});
        check({"model_", name}, {16'd0, ref_mul(a, b)}, {16'd0, lit});
    endtask

    task automatic wait_done();
        for (int k = 0; k < 60; k++) begin
            if (done) return;
            @(negedge clk);
        end
        check("wait_done_timeout", {31'd0, done}, 32'd1);
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] specials [6];
        specials = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001, 16'h0000, 16'h0100};
        case ($urandom_range(0, 3))
            0, 1:    return W'($urandom);
            2:       return W'($signed($urandom_range(0, 2047)) - 1024);
            default: return specials[$urandom_range(0, 5)];
        endcase
    endfunction

    initial begin
        int cyc;
        bit saw_valid;
        rst = 1; start = 0; ia = '0; ib = '0;
        repeat (2) @(negedge clk);
        check_en = 1;
        rst = 0;
        @(negedge clk);
        check("reset_done", {31'd0, done}, 32'd1);
        check("reset_valid", {31'd0, o_valid}, 32'd0);
        check("reset_result", {16'd0, o_result}, 32'h0000);

        do_op(16'h0180, 16'h0200, 16'h0300, "1.5x2");
        do_op(16'hFE80, 16'h0200, 16'hFD00, "-1.5x2");
        do_op(16'h0080, 16'hFF80, 16'hFFC0, "0.5x-0.5");
        do_op(16'h0001, 16'h0001, 16'h0000, "tiny_pos");
        do_op(16'hFFFF, 16'h0001, 16'h0000, "tiny_neg");
        do_op(16'h8000, 16'h0100, 16'h8000, "most_neg");
`ifdef MUL_SATURATE_EN
        do_op(16'h6400, 16'h0200, 16'h7FFF, "ovf_pos");
        do_op(16'h9C00, 16'h0200, 16'h8000, "ovf_neg");
`else
        do_op(16'h6400, 16'h0200, 16'hC800, "ovf_pos");
        do_op(16'h9C00, 16'h0200, 16'h3800, "ovf_neg");
`endif

        // New operands offered mid-RUN must be ignored
        @(negedge clk);
        ia = 16'h0180; ib = 16'h0200; start = 1;
        @(negedge clk);
        start = 0;
        repeat (5) @(negedge clk);
        ia = 16'h7000; ib = 16'h7000; start = 1;
        repeat (3) @(negedge clk);
        start = 0;
        wait_valid(cyc);
        check("midrun_ignore", {16'd0, o_result}, 32'h0300);

        // start held high: re-accept on the edge after done rises
        @(negedge clk);
        ia = 16'h0180; ib = 16'h0200; start = 1;
        wait_valid(cyc);
        check("held_first", {16'd0, o_result}, 32'h0300);
        ia = 16'h0080; ib = 16'hFF80;
        @(negedge clk);
        check("held_reaccept_valid", {31'd0, o_valid}, 32'd0);
        check("held_reaccept_done", {31'd0, done}, 32'd0);
        start = 0;
        wait_valid(cyc);
        check("held_second", {16'd0, o_result}, 32'hFFC0);

        // Reset in the fifth RUN cycle aborts without a valid pulse
        @(negedge clk);
        ia = 16'h0400; ib = 16'h0400; start = 1;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("abort_done", {31'd0, done}, 32'd1);
        check("abort_valid", {31'd0, o_valid}, 32'd0);
        check("abort_result", {16'd0, o_result}, 32'h0000);
        saw_valid = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_valid) saw_valid = 1;
        end
        check("abort_no_valid", {31'd0, saw_valid}, 32'd0);
        do_op(16'h0180, 16'h0200, 16'h0300, "after_abort");

        for (int i = 0; i < 150; i++) begin
            int hold;
            @(negedge clk);
            ia = pick_operand(); ib = pick_operand(); start = 1;
            hold = $urandom_range(1, 3);
            repeat (hold) @(negedge clk);
            start = 0;
            if ($urandom_range(0, 19) == 0) begin
                repeat ($urandom_range(1, 16)) @(negedge clk);
                rst = 1;
                @(negedge clk);
                rst = 0;
            end else begin
                wait_done();
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mul_seq.md
# mul_seq

Sequential signed fixed-point multiplier: the shift-add counterpart to the team's restoring divider. It uses the same `WIDTH`/`QBITS` Q-format and the same `i_start`/`done`/`o_valid` handshake, so both blocks can sit side by side behind one arithmetic controller. It computes `a*b` by sign-magnitude shift-add, producing one partial product bit per cycle.

## Interface
- `WIDTH`, 16: operand and result width, signed two's complement.
- `QBITS`, 8: fractional bits. Must satisfy 0 <= QBITS < WIDTH.

- `i_clk`  in  1: clock; all state updates on the rising edge.
- `i_rst`  in  1: synchronous, active-high reset.
- `i_a`  in  WIDTH: signed multiplicand, Q(WIDTH-QBITS).QBITS.
- `i_b`  in  WIDTH: signed multiplier, same format.
- `i_start`  in  1: request. Accepted only on an edge where `i_start && done`.
- `o_result`  out  WIDTH: signed product, same format.
- `done`  out  1: high when idle or finished; low while busy.
- `o_valid`  out  1: `o_result` holds a completed product.

## Operation
- States:
  - IDLE (`done`=1).
  - RUN (`done`=0, iteration counter 0..WIDTH-1).
  - FINISH (`done`=0, one cycle).
- IDLE->RUN on accepted start. On that edge:
  - latch |a| and |b| into WIDTH-bit unsigned registers; |-2^(WIDTH-1)| = 2^(WIDTH-1) fits unsigned.
  - latch sign = a[MSB]^b[MSB].
  - clear the 2*WIDTH accumulator and the counter.
  - clear `o_valid` and `o_result`.
- RUN, each cycle:
  - if the current multiplier LSB is 1, add |a| shifted into the 2*WIDTH accumulator; shift the multiplier right.
  - Equivalent MSB-first ordering is allowed; the result must be bit-exact either way.
  - After WIDTH iterations, go to FINISH.
- FINISH:
  - M = accumulator >> QBITS, held in 2*WIDTH-QBITS bits. This truncates the magnitude, so the signed result rounds toward zero.
  - Apply the sign: negate if sign=1. A zero magnitude always yields 0.
  - Register into `o_result`, set `o_valid`=1 and `done`=1, go to IDLE.
- `i_start` while `done`=0 is ignored; operands are not re-sampled.
- `o_valid` and `o_result` hold until the next accepted start or reset.
- Back-to-back: a start on the same edge FINISH completes is not accepted, because `done` is still 0 at that edge. The earliest next accept is the following edge.
- No illegal inputs: every operand pair produces a result.

## Timing
- Reset values: `done`=1, `o_valid`=0, `o_result`=0, state IDLE, counter 0.
- Start accepted at edge E0:
  - `done` falls after E0.
  - `o_valid` rises and `done` rises after edge E0+WIDTH+1.
  - Latency is WIDTH+1 cycles; throughput is one product per WIDTH+2 cycles.
- `i_rst` has priority over everything, including a simultaneous `i_start`. Reset mid-RUN or mid-FINISH aborts the operation, returns to reset values, and produces no `o_valid` pulse.
- `o_result` changes only on the accept edge (cleared to 0) and on the FINISH edge.

## Configuration
- `MUL_SATURATE_EN`, defined:
  - FINISH clamps out-of-range results. Positive result with M > 2^(WIDTH-1)-1 gives 0x7FFF (for WIDTH=16); negative result with M > 2^(WIDTH-1) gives 0x8000.
  - An exact -2^(WIDTH-1) is not clamped.
- Undefined:
  - no clamp; `o_result` is the low WIDTH bits of the signed result (two's complement wrap).
  - No saturation logic is instantiated.

## Test plan
All scenarios use WIDTH=16, QBITS=8.
- Reset, then idle: `done`=1, `o_valid`=0, `o_result`=0x0000. A=0x0180 (1.5), B=0x0200 (2.0), start -> `o_valid` after 17 cycles, `o_result`=0x0300. A=0xFE80, B=0x0200 -> 0xFD00 (-3.0). A=0x0080, B=0xFF80 -> 0xFFC0 (-0.25).
- Truncation toward zero: 0x0001*0x0001 -> 0x0000; 0xFFFF*0x0001 -> 0x0000 (not 0xFFFF). Most negative input: 0x8000*0x0100 -> 0x8000 in both builds.
- Overflow: 0x6400*0x0200 (100*2) -> 0xC800 without the macro, 0x7FFF with `MUL_SATURATE_EN`. 0x9C00*0x0200 (-100*2) -> 0x3800 without it, 0x8000 with it.
- Handshake:
  - `i_start` held high with new operands mid-RUN -> ignored; first result unchanged.
  - `i_start` held high continuously -> next accept on the edge after `done` rises; `o_valid` cleared on that accept.
- Reset mid-operation: assert `i_rst` at cycle 5 of RUN for one cycle -> reset values next cycle, no `o_valid` pulse. A following start (0x0180*0x0200) completes normally with 0x0300.
